store_forward_buffer: RTL and testbench
=======================================

// Module: store_forward_buffer
// PURPOSE
// - Receiving end of the load/store unit's store and forwarding interfaces. Holds executed stores in program order until the ROB commits them.
// - Answers same-cycle load forwarding lookups and drains committed stores to the data cache write port.
// - Sits between the load/store unit, the ROB and the data cache.
// PARAMETERS
// DATA_WIDTH  32  store/load data bits; must be 32 (4 byte lanes)
// ADDR_BITS   32  address bits
// MICROOP     5   microoperation bits
// ROB_TICKET  3   ROB ticket bits
// DEPTH       8   buffer entries; power of 2, >=4
// PORTS
// clk                    in   1           clock, all state updates on rising edge
// rst                    in   1           synchronous, active-high reset
// store_valid            in   1           executed store from LSU; no backpressure
// store_address          in   ADDR_BITS   store byte address
// store_data             in   DATA_WIDTH  raw rs2 value, right-justified
// store_microop          in   MICROOP     SW/SH/SB
// store_ticket           in   ROB_TICKET  ROB ticket of the store
// commit_valid           in   1           ROB commits its oldest store this cycle
// commit_ticket          in   ROB_TICKET  ticket of the committing store
// flush                  in   1           misprediction; discard all uncommitted entries
// frw_address            in   ADDR_BITS   load lookup address
// frw_microop            in   MICROOP     load microop (LW/LH/LHU/LB/LBU)
// frw_data               out  DATA_WIDTH  forwarded bytes, right-justified, not extended
// frw_valid              out  1           load fully covered by youngest overlapping store
// frw_stall              out  1           partial overlap; load must retry
// sfb_full               out  1           count >= DEPTH-1; issue stalls new stores
// cache_writeback_valid  out  1           head entry committed; write to cache
// cache_wb_addr          out  ADDR_BITS   head address
// cache_wb_data          out  DATA_WIDTH  head raw data
// cache_wb_microop       out  MICROOP     head microop
// cache_wb_ready         in   1           cache accepts writeback this cycle
// sfb_error              out  1           sticky: overflow or commit ticket mismatch
// BEHAVIOUR
// - State: circular array, head (oldest), tail, count, ncommit (committed entries from head). Entry = {addr, data, microop, ticket, committed}.
// - Reset: head=tail=count=ncommit=0, sfb_error=0. All outputs 0 (frw_data=0, cache_writeback_valid=0, sfb_full=0).
// - Push: store_valid writes entry[tail] with committed=0, tail+1 mod DEPTH. If push happens with count==DEPTH, the store is dropped and sfb_error is set.
// - Commit: commit_valid marks entry[head+ncommit] committed, ncommit+1.
//   - If commit_ticket differs from that entry's ticket, or if ncommit==count, set sfb_error.
// - Drain: cache_writeback_valid = (ncommit!=0). It drives head fields combinationally.
//   - On cache_wb_ready: head+1, count-1, ncommit-1.
// - Flush: tail = head+ncommit' and count = ncommit', using post-commit/post-drain values. Flush takes priority over a same-cycle push, which is discarded.
// - Same-cycle ordering: drain, then commit, then push, then flush. count updates by the net change. Push and drain while full are legal; the push is still dropped if count was DEPTH.
// - Byte masks:
//   - SW = 4'b1111
//   - SH / LH / LHU = 4'b0011 << a[1:0]
//   - SB / LB / LBU = 4'b0001 << a[1:0]
//   - Bits shifted past lane 3 are discarded.
// - Lane data: store lanes = data << 8*a[1:0].
// - Lookup is purely combinational, with 0-cycle latency. It compares word addresses a[ADDR_BITS-1:2] over all valid entries, committed or not.
//   - Select the youngest entry whose mask overlaps the load mask.
//   - Full cover (smask & lmask == lmask): frw_valid=1, frw_data = (lanes >> 8*load a[1:0]) masked to the load size.
//   - Partial cover: frw_stall=1, frw_valid=0, frw_data=0.
//   - No overlap, or a non-load microop: all three outputs are 0.
// - A store pushed in cycle N is visible to lookups from cycle N+1. Lookups never see same-cycle pushes.
// - sfb_full registers nothing; it is computed from the current count.
// - Reset mid-operation discards every entry, committed ones included. Data loss on reset is accepted.
// STRUCTURE
// - Shared package (structs.sv):
//   - microop constants: SW=5'b00110, SH=5'b00111, SB=5'b01000, LW=5'b00001, LH=5'b00010, LB=5'b00011, LHU=5'b00100, LBU=5'b00101
//   - function byte_mask(microop, addr[1:0])
//   - typedef sfb_entry
// - Sub-module sfb_age_match: per-entry overlap vector plus age-priority (youngest from tail-1 downward) one-hot select. Shared by frw_valid and frw_stall.
// TESTING
// - SW 0x100 data 0xDEADBEEF; next cycle LW 0x100 -> frw_valid=1, frw_data=0xDEADBEEF; LB 0x103 -> frw_data=0x000000DE.
// - SB 0x102 data 0x55; LW 0x100 -> frw_stall=1, frw_valid=0; LBU 0x102 -> frw_valid=1, frw_data=0x55.
// - SW 0x200 0x11111111, then SW 0x200 0x22222222; LW 0x200 -> frw_data=0x22222222 (youngest wins).
// - Push 3 stores (tickets 1,2,3); commit ticket 1 with cache_wb_ready=0 -> cache_writeback_valid=1 holds with address of store 1. Then flush -> count=1. Then ready=1 -> empty, sfb_full=0.
// - Push 7 entries (DEPTH=8) -> sfb_full=1. Push a 9th with no drain -> sfb_error=1, count stays 8.
// - commit_ticket=5 while the oldest uncommitted entry has ticket 4 -> sfb_error=1. rst=1 for one cycle -> all outputs 0, count=0.

Source files
------------

// File: rtl/store_forward_buffer_pkg.sv
// Shared types and helpers for the store forwarding buffer.
package store_forward_buffer_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int UOP_W    = 5;
    localparam int TICKET_W = 3;

    localparam logic [UOP_W-1:0] LW  = 5'b00001;
    localparam logic [UOP_W-1:0] LH  = 5'b00010;
    localparam logic [UOP_W-1:0] LB  = 5'b00011;
    localparam logic [UOP_W-1:0] LHU = 5'b00100;
    localparam logic [UOP_W-1:0] LBU = 5'b00101;
    localparam logic [UOP_W-1:0] SW  = 5'b00110;
    localparam logic [UOP_W-1:0] SH  = 5'b00111;
    localparam logic [UOP_W-1:0] SB  = 5'b01000;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [UOP_W-1:0]    microop;
        logic [TICKET_W-1:0] ticket;
        logic                committed;
    } sfb_entry;

    // Byte lanes touched by an access; lanes shifted past byte 3 fall off.
    function automatic logic [3:0] byte_mask(input logic [UOP_W-1:0] uop, input logic [1:0] a);
        logic [3:0] half;
        logic [3:0] one;
        half = 4'b0011;
        one  = 4'b0001;
        case (uop)
            SW, LW:       byte_mask = 4'b1111;
            SH, LH, LHU:  byte_mask = half << a;
            SB, LB, LBU:  byte_mask = one << a;
            default:      byte_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic is_load(input logic [UOP_W-1:0] uop);
        is_load = (uop == LW) || (uop == LH) || (uop == LB) || (uop == LHU) || (uop == LBU);
    endfunction

    // Keeps only the bytes a load returns; forwarded data is never extended.
    function automatic logic [DATA_W-1:0] size_mask(input logic [UOP_W-1:0] uop);
        case (uop)
            LW:       size_mask = 32'hFFFF_FFFF;
            LH, LHU:  size_mask = 32'h0000_FFFF;
            LB, LBU:  size_mask = 32'h0000_00FF;
            default:  size_mask = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/store_forward_buffer_age_match.sv
// Youngest-overlap picker: walks valid entries oldest to youngest so the
// last hit (closest to tail-1) wins, producing a one-hot entry select.
module sfb_age_match #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int CNT_W = IDX_W + 1
) (
    input  logic [DEPTH-1:0] overlap,
    input  logic [IDX_W-1:0] head,
    input  logic [CNT_W-1:0] count,
    output logic [DEPTH-1:0] sel,
    output logic             hit
);

    // Later (younger) matches overwrite earlier ones; entries past count are ignored.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count) && overlap[head + IDX_W'(k)]) begin
                sel                    = '0;
                sel[head + IDX_W'(k)]  = 1'b1;
                hit                    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_forward_buffer.sv
// Store buffer: holds executed stores in program order, forwards to loads
// combinationally, and drains ROB-committed stores to the data cache.
module store_forward_buffer
    import store_forward_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_BITS  = ADDR_W,
    parameter int MICROOP    = UOP_W,
    parameter int ROB_TICKET = TICKET_W,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  store_valid,
    input  logic [ADDR_BITS-1:0]  store_address,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [MICROOP-1:0]    store_microop,
    input  logic [ROB_TICKET-1:0] store_ticket,
    input  logic                  commit_valid,
    input  logic [ROB_TICKET-1:0] commit_ticket,
    input  logic                  flush,
    input  logic [ADDR_BITS-1:0]  frw_address,
    input  logic [MICROOP-1:0]    frw_microop,
    output logic [DATA_WIDTH-1:0] frw_data,
    output logic                  frw_valid,
    output logic                  frw_stall,
    output logic                  sfb_full,
    output logic                  cache_writeback_valid,
    output logic [ADDR_BITS-1:0]  cache_wb_addr,
    output logic [DATA_WIDTH-1:0] cache_wb_data,
    output logic [MICROOP-1:0]    cache_wb_microop,
    input  logic                  cache_wb_ready,
    output logic                  sfb_error
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    sfb_entry entries [DEPTH];

    logic [IDX_W-1:0] head, tail;
    logic [CNT_W-1:0] count, ncommit;

    logic             drain, commit_ok, push_ok, err_set;
    logic [IDX_W-1:0] head_n, tail_n, commit_idx;
    logic [CNT_W-1:0] count_n, ncommit_n, count_d, ncommit_d;

    // Same-cycle order: drain, commit, push, flush; count moves by the net change.
    always_comb begin
        drain      = (ncommit != '0) && cache_wb_ready;
        head_n     = head + IDX_W'(drain);
        count_d    = count - CNT_W'(drain);
        ncommit_d  = ncommit - CNT_W'(drain);
        commit_idx = head + ncommit[IDX_W-1:0];
        commit_ok  = commit_valid && (ncommit != count);
        ncommit_n  = ncommit_d + CNT_W'(commit_ok);
        push_ok    = store_valid && (count != CNT_W'(DEPTH)) && !flush;
        err_set    = (store_valid && (count == CNT_W'(DEPTH)))
                   || (commit_valid && (!commit_ok || entries[commit_idx].ticket != commit_ticket));
        tail_n     = tail + IDX_W'(push_ok);
        count_n    = count_d + CNT_W'(push_ok);
        if (flush) begin
            tail_n  = head_n + ncommit_n[IDX_W-1:0];
            count_n = ncommit_n;
        end
    end

    // Pointer, occupancy and sticky error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ncommit   <= '0;
            sfb_error <= 1'b0;
        end else begin
            head      <= head_n;
            tail      <= tail_n;
            count     <= count_n;
            ncommit   <= ncommit_n;
            sfb_error <= sfb_error | err_set;
        end
    end

    // Entry payload; stale slots are harmless because validity comes from head/count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (commit_ok)
                entries[commit_idx].committed <= 1'b1;
            if (push_ok)
                entries[tail] <= '{addr: store_address, data: store_data, microop: store_microop,
                                   ticket: store_ticket, committed: 1'b0};
        end
    end

    assign sfb_full              = count >= CNT_W'(DEPTH - 1);
    assign cache_writeback_valid = (ncommit != '0) && entries[head].committed;
    assign cache_wb_addr         = entries[head].addr;
    assign cache_wb_data         = entries[head].data;
    assign cache_wb_microop      = entries[head].microop;

    // Forwarding lookup
    logic [3:0]                  lmask;
    logic [DEPTH-1:0][3:0]       smask;
    logic [DEPTH-1:0][DATA_W-1:0] lanes;
    logic [DEPTH-1:0]            overlap, sel;
    logic                        hit, full_cover;
    logic [3:0]                  sel_mask;
    logic [DATA_W-1:0]           sel_lanes;

    assign lmask = is_load(frw_microop) ? byte_mask(frw_microop, frw_address[1:0]) : 4'b0000;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign smask[g]   = byte_mask(entries[g].microop, entries[g].addr[1:0]);
        assign lanes[g]   = entries[g].data << {entries[g].addr[1:0], 3'b000};
        assign overlap[g] = (entries[g].addr[ADDR_BITS-1:2] == frw_address[ADDR_BITS-1:2])
                          && ((smask[g] & lmask) != 4'b0000);
    end

    sfb_age_match #(.DEPTH(DEPTH)) u_age (
        .overlap (overlap),
        .head    (head),
        .count   (count),
        .sel     (sel),
        .hit     (hit)
    );

    // One-hot mux of the selected entry's mask and lane-aligned data.
    always_comb begin
        sel_mask  = '0;
        sel_lanes = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                sel_mask  = sel_mask | smask[i];
                sel_lanes = sel_lanes | lanes[i];
            end
        end
    end

    assign full_cover = (sel_mask & lmask) == lmask;
    assign frw_valid  = hit && full_cover;
    assign frw_stall  = hit && !full_cover;
    assign frw_data   = frw_valid ? ((sel_lanes >> {frw_address[1:0], 3'b000}) & size_mask(frw_microop))
                                  : '0;

endmodule

// File: tb/tb_store_forward_buffer.sv
// Directed bench with scoreboards for forwarding lookups and cache writebacks.
module tb_store_forward_buffer;
    import store_forward_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        store_valid;
    logic [31:0] store_address, store_data;
    logic [4:0]  store_microop;
    logic [2:0]  store_ticket;
    logic        commit_valid;
    logic [2:0]  commit_ticket;
    logic        flush;
    logic [31:0] frw_address;
    logic [4:0]  frw_microop;
    logic [31:0] frw_data;
    logic        frw_valid, frw_stall, sfb_full;
    logic        cache_writeback_valid;
    logic [31:0] cache_wb_addr, cache_wb_data;
    logic [4:0]  cache_wb_microop;
    logic        cache_wb_ready;
    logic        sfb_error;

    store_forward_buffer dut (
        .clk(clk), .rst(rst),
        .store_valid(store_valid), .store_address(store_address), .store_data(store_data),
        .store_microop(store_microop), .store_ticket(store_ticket),
        .commit_valid(commit_valid), .commit_ticket(commit_ticket), .flush(flush),
        .frw_address(frw_address), .frw_microop(frw_microop),
        .frw_data(frw_data), .frw_valid(frw_valid), .frw_stall(frw_stall),
        .sfb_full(sfb_full), .cache_writeback_valid(cache_writeback_valid),
        .cache_wb_addr(cache_wb_addr), .cache_wb_data(cache_wb_data),
        .cache_wb_microop(cache_wb_microop), .cache_wb_ready(cache_wb_ready),
        .sfb_error(sfb_error)
    );

    always #5 clk = ~clk;

    typedef struct { logic v; logic s; logic [31:0] d; } frw_exp_t;
    typedef struct { logic [31:0] a; logic [31:0] d; logic [4:0] u; } wb_exp_t;
    frw_exp_t fq[$];
    wb_exp_t  wq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [4:0] u, input logic [2:0] t);
        store_valid = 1'b1; store_address = a; store_data = d; store_microop = u; store_ticket = t;
        tick();
        store_valid = 1'b0;
    endtask

    task automatic commit(input logic [2:0] t);
        commit_valid = 1'b1; commit_ticket = t;
        tick();
        commit_valid = 1'b0;
    endtask

    // Expectation is queued as the lookup is driven, then popped once outputs settle.
    task automatic lookup(input string tag, input logic [31:0] a, input logic [4:0] u,
                          input logic ev, input logic es, input logic [31:0] ed);
        frw_exp_t e;
        frw_address = a; frw_microop = u;
        fq.push_back('{v: ev, s: es, d: ed});
        #1;
        e = fq.pop_front();
        chk({tag, ".valid"}, 32'(frw_valid), 32'(e.v));
        chk({tag, ".stall"}, 32'(frw_stall), 32'(e.s));
        chk({tag, ".data"},  frw_data,        e.d);
    endtask

    task automatic check_wb_head(input string tag);
        chk({tag, ".wbv"}, 32'(cache_writeback_valid), 32'd1);
        if (wq.size() == 0) begin
            n_cmp++; n_bad++;
            $error("FAIL %s.wbq: observed writeback expected none queued", tag);
        end else begin
            chk({tag, ".wba"}, cache_wb_addr,           wq[0].a);
            chk({tag, ".wbd"}, cache_wb_data,           wq[0].d);
            chk({tag, ".wbu"}, 32'(cache_wb_microop),   32'(wq[0].u));
        end
    endtask

    task automatic drain_one();
        cache_wb_ready = 1'b1;
        tick();
        cache_wb_ready = 1'b0;
        if (wq.size() != 0) void'(wq.pop_front());
    endtask

    initial begin
        rst = 1'b0; store_valid = 1'b0; store_address = '0; store_data = '0; store_microop = '0;
        store_ticket = '0; commit_valid = 1'b0; commit_ticket = '0; flush = 1'b0;
        frw_address = '0; frw_microop = '0; cache_wb_ready = 1'b0;
        tick();
        do_reset();

        chk("rst.frw_valid", 32'(frw_valid), 32'd0);
        chk("rst.frw_stall", 32'(frw_stall), 32'd0);
        chk("rst.frw_data",  frw_data,       32'd0);
        chk("rst.wbv",       32'(cache_writeback_valid), 32'd0);
        chk("rst.full",      32'(sfb_full),  32'd0);
        chk("rst.err",       32'(sfb_error), 32'd0);

        // Store is not visible in the cycle it is pushed.
        store_valid = 1'b1; store_address = 32'h100; store_data = 32'hDEAD_BEEF;
        store_microop = SW; store_ticket = 3'd0;
        lookup("same_cycle", 32'h100, LW, 1'b0, 1'b0, 32'h0);
        tick();
        store_valid = 1'b0;
        lookup("sw_lw",    32'h100, LW,  1'b1, 1'b0, 32'hDEAD_BEEF);
        lookup("sw_lb3",   32'h103, LB,  1'b1, 1'b0, 32'h0000_00DE);
        lookup("sw_lh2",   32'h102, LH,  1'b1, 1'b0, 32'h0000_DEAD);
        lookup("sw_lbu1",  32'h101, LBU, 1'b1, 1'b0, 32'h0000_00BE);

        // Byte store over the word: upper rs2 bits must not leak in.
        push(32'h102, 32'hAAAA_AA55, SB, 3'd1);
        lookup("sb_lw_part", 32'h100, LW,  1'b0, 1'b1, 32'h0);
        lookup("sb_lbu",     32'h102, LBU, 1'b1, 1'b0, 32'h0000_0055);
        lookup("sb_lb3_old", 32'h103, LB,  1'b1, 1'b0, 32'h0000_00DE);
        lookup("nonload",    32'h100, SW,  1'b0, 1'b0, 32'h0);
        lookup("miss",       32'h104, LW,  1'b0, 1'b0, 32'h0);

        do_reset();
        push(32'h200, 32'h1111_1111, SW, 3'd0);
        push(32'h200, 32'h2222_2222, SW, 3'd1);
        lookup("youngest", 32'h200, LW, 1'b1, 1'b0, 32'h2222_2222);

        // Commit with the cache stalled, then flush the uncommitted tail.
        do_reset();
        push(32'h300, 32'hA1A1_A1A1, SW, 3'd1);
        push(32'h304, 32'hA2A2_A2A2, SW, 3'd2);
        push(32'h308, 32'hA3A3_A3A3, SW, 3'd3);
        wq.push_back('{a: 32'h300, d: 32'hA1A1_A1A1, u: SW});
        commit(3'd1);
        check_wb_head("commit1");
        tick();
        check_wb_head("hold");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_wb_head("post_flush");
        chk("flush.full", 32'(sfb_full), 32'd0);
        lookup("flushed_304", 32'h304, LW, 1'b0, 1'b0, 32'h0);
        lookup("kept_300",    32'h300, LW, 1'b1, 1'b0, 32'hA1A1_A1A1);
        drain_one();
        chk("drain.wbv",  32'(cache_writeback_valid), 32'd0);
        chk("drain.full", 32'(sfb_full), 32'd0);
        lookup("empty_300", 32'h300, LW, 1'b0, 1'b0, 32'h0);
        // Tail was rewound by the flush, so the next store lands right after head.
        push(32'h30C, 32'hB0B0_B0B0, SH, 3'd2);
        wq.push_back('{a: 32'h30C, d: 32'hB0B0_B0B0, u: SH});
        commit(3'd2);
        check_wb_head("reuse");
        chk("reuse.err", 32'(sfb_error), 32'd0);
        drain_one();
        chk("reuse.drained", 32'(cache_writeback_valid), 32'd0);

        // Fill to DEPTH and overflow.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push(32'h500 + 32'(4 * i), 32'(i + 1), SW, 3'(i));
            if (i == 5) chk("fill6.full", 32'(sfb_full), 32'd0);
            if (i == 6) chk("fill7.full", 32'(sfb_full), 32'd1);
            if (i == 7) chk("fill8.err",  32'(sfb_error), 32'd0);
        end
        chk("ovf.err",  32'(sfb_error), 32'd1);
        chk("ovf.full", 32'(sfb_full),  32'd1);
        lookup("ovf_dropped", 32'h520, LW, 1'b0, 1'b0, 32'h0);
        lookup("ovf_last",    32'h51C, LW, 1'b1, 1'b0, 32'd8);
        lookup("ovf_first",   32'h500, LW, 1'b1, 1'b0, 32'd1);

        do_reset();
        chk("rst2.err", 32'(sfb_error), 32'd0);
        commit(3'd0);
        chk("commit_empty.err", 32'(sfb_error), 32'd1);

        do_reset();
        push(32'h400, 32'h4444_4444, SW, 3'd4);
        commit(3'd5);
        chk("tkt.err", 32'(sfb_error), 32'd1);
        chk("tkt.wbv", 32'(cache_writeback_valid), 32'd1);
        do_reset();
        chk("rst3.err",  32'(sfb_error), 32'd0);
        chk("rst3.wbv",  32'(cache_writeback_valid), 32'd0);
        chk("rst3.full", 32'(sfb_full), 32'd0);
        lookup("rst3_empty", 32'h400, LW, 1'b0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
